// File: rtl/gopigo3_spi_responder.sv
// GoPiGo3-style SPI mode-0 responder: motor DPS commands and encoder tick readback.
// Define GOPIGO3_RESP_LED_EN to add the SET_LED message (type 8'h14) and four RGB LED outputs.
module gopigo3_spi_responder #(
  parameter logic [7:0] G_ADDR = 8'h08
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sclk_i,
  input  logic        ss_n_i,
  input  logic        mosi_i,
  output logic        miso_o,
  output logic        miso_en_o,
  input  logic [31:0] motor_ticks_left_i,
  input  logic [31:0] motor_ticks_rght_i,
  output logic [15:0] motor_dps_left_o,
  output logic [15:0] motor_dps_rght_o,
  output logic        dps_upd_o,
  output logic        ticks_rd_left_o,
  output logic        ticks_rd_rght_o,
`ifdef GOPIGO3_RESP_LED_EN
  output logic [23:0] led_eye_left_rgb_o,
  output logic [23:0] led_eye_rght_rgb_o,
  output logic [23:0] led_blink_left_rgb_o,
  output logic [23:0] led_blink_rght_rgb_o,
`endif
  output logic        frame_err_o
);

  typedef enum logic [2:0] {StIdle, StAddr, StType, StPayload, StIgnore} state_e;

  localparam logic [7:0] TypeTicksLeft = 8'h11;
  localparam logic [7:0] TypeTicksRght = 8'h12;
  localparam logic [7:0] TypeSetDps    = 8'h13;
`ifdef GOPIGO3_RESP_LED_EN
  localparam logic [7:0] TypeSetLed    = 8'h14;
  localparam int unsigned MaskW = 4;
`else
  localparam int unsigned MaskW = 2;
`endif

  state_e           state_q;
  logic [1:0]       sclk_sync, ss_sync, mosi_sync;
  logic             sclk_prev, ss_prev;
  logic [2:0]       bit_cnt_q;
  logic [3:0]       byte_cnt_q;
  logic [7:0]       rx_q, tx_q, type_q, data_q;
  logic [MaskW-1:0] mask_q;
  logic [31:0]      snap_q;
`ifdef GOPIGO3_RESP_LED_EN
  logic [7:0]       green_q;
`endif

  logic       sclk_rise, sclk_fall, ss_fall, ss_rise;
  logic [7:0] rx_byte, tx_next;
  logic [3:0] msg_len;

  assign sclk_rise = sclk_sync[1] & ~sclk_prev;
  assign sclk_fall = ~sclk_sync[1] & sclk_prev;
  assign ss_fall   = ss_prev & ~ss_sync[1];
  assign ss_rise   = ~ss_prev & ss_sync[1];
  assign rx_byte   = {rx_q[6:0], mosi_sync[1]};

  always_comb begin
    msg_len = 4'd0;
    case (type_q)
      TypeTicksLeft, TypeTicksRght: msg_len = 4'd7;
      TypeSetDps:                   msg_len = 4'd5;
`ifdef GOPIGO3_RESP_LED_EN
      TypeSetLed:                   msg_len = 4'd6;
`endif
      default:                      msg_len = 4'd0;
    endcase
  end

  // Byte to present next; byte_cnt_q already counts the byte just completed.
  always_comb begin
    tx_next = 8'h00;
    if (state_q == StPayload && (type_q == TypeTicksLeft || type_q == TypeTicksRght)) begin
      case (byte_cnt_q)
        4'd2:    tx_next = 8'hA5;
        4'd3:    tx_next = snap_q[31:24];
        4'd4:    tx_next = snap_q[23:16];
        4'd5:    tx_next = snap_q[15:8];
        4'd6:    tx_next = snap_q[7:0];
        default: tx_next = 8'h00;
      endcase
    end
  end

  // ss sync resets low so a frame already in progress at reset release is never mistaken
  // for a fresh ss_n fall; the FSM waits in StIgnore until ss_n is seen high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= StIgnore;
      sclk_sync        <= 2'b00;
      ss_sync          <= 2'b00;
      mosi_sync        <= 2'b00;
      sclk_prev        <= 1'b0;
      ss_prev          <= 1'b0;
      bit_cnt_q        <= 3'd0;
      byte_cnt_q       <= 4'd0;
      rx_q             <= 8'h00;
      tx_q             <= 8'h00;
      type_q           <= 8'h00;
      data_q           <= 8'h00;
      mask_q           <= '0;
      snap_q           <= 32'h0;
      miso_o           <= 1'b0;
      miso_en_o        <= 1'b0;
      motor_dps_left_o <= 16'h0000;
      motor_dps_rght_o <= 16'h0000;
      dps_upd_o        <= 1'b0;
      ticks_rd_left_o  <= 1'b0;
      ticks_rd_rght_o  <= 1'b0;
      frame_err_o      <= 1'b0;
`ifdef GOPIGO3_RESP_LED_EN
      green_q              <= 8'h00;
      led_eye_left_rgb_o   <= 24'h0;
      led_eye_rght_rgb_o   <= 24'h0;
      led_blink_left_rgb_o <= 24'h0;
      led_blink_rght_rgb_o <= 24'h0;
`endif
    end else begin
      sclk_sync       <= {sclk_sync[0], sclk_i};
      ss_sync         <= {ss_sync[0], ss_n_i};
      mosi_sync       <= {mosi_sync[0], mosi_i};
      sclk_prev       <= sclk_sync[1];
      ss_prev         <= ss_sync[1];
      dps_upd_o       <= 1'b0;
      ticks_rd_left_o <= 1'b0;
      ticks_rd_rght_o <= 1'b0;
      frame_err_o     <= 1'b0;

      if (ss_rise) begin
        if (state_q == StType || (state_q == StPayload && byte_cnt_q < msg_len)) begin
          frame_err_o <= 1'b1;
        end
        state_q   <= StIdle;
        miso_en_o <= 1'b0;
        miso_o    <= 1'b0;
      end else if (ss_fall && state_q == StIdle) begin
        state_q    <= StAddr;
        miso_en_o  <= 1'b1;
        miso_o     <= 1'b0;
        bit_cnt_q  <= 3'd0;
        byte_cnt_q <= 4'd0;
        rx_q       <= 8'h00;
        tx_q       <= 8'h00;
      end else if (state_q inside {StAddr, StType, StPayload}) begin
        if (sclk_rise) begin
          rx_q      <= rx_byte;
          bit_cnt_q <= bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (byte_cnt_q != 4'hF) byte_cnt_q <= byte_cnt_q + 4'd1;
            case (state_q)
              StAddr: begin
                if (rx_byte == G_ADDR) begin
                  state_q <= StType;
                end else begin
                  state_q   <= StIgnore;
                  miso_en_o <= 1'b0;
                  miso_o    <= 1'b0;
                end
              end
              StType: begin
                type_q  <= rx_byte;
                state_q <= StPayload;
                case (rx_byte)
                  TypeTicksLeft: begin
                    snap_q          <= motor_ticks_left_i;
                    ticks_rd_left_o <= 1'b1;
                  end
                  TypeTicksRght: begin
                    snap_q          <= motor_ticks_rght_i;
                    ticks_rd_rght_o <= 1'b1;
                  end
                  TypeSetDps: ;
`ifdef GOPIGO3_RESP_LED_EN
                  TypeSetLed: ;
`endif
                  default: begin
                    state_q   <= StIgnore;
                    miso_en_o <= 1'b0;
                    miso_o    <= 1'b0;
                  end
                endcase
              end
              StPayload: begin
                // Bytes past the message length fall through untouched.
                if (byte_cnt_q < msg_len) begin
                  case (byte_cnt_q)
                    4'd2: mask_q <= rx_byte[MaskW-1:0];
                    4'd3: data_q <= rx_byte;
                    4'd4: begin
                      if (type_q == TypeSetDps) begin
                        if (mask_q[0]) motor_dps_left_o <= {data_q, rx_byte};
                        if (mask_q[1]) motor_dps_rght_o <= {data_q, rx_byte};
                        dps_upd_o <= |mask_q[1:0];
                      end
`ifdef GOPIGO3_RESP_LED_EN
                      green_q <= rx_byte;
`endif
                    end
`ifdef GOPIGO3_RESP_LED_EN
                    4'd5: begin
                      if (type_q == TypeSetLed) begin
                        if (mask_q[0]) led_eye_left_rgb_o   <= {data_q, green_q, rx_byte};
                        if (mask_q[1]) led_eye_rght_rgb_o   <= {data_q, green_q, rx_byte};
                        if (mask_q[2]) led_blink_left_rgb_o <= {data_q, green_q, rx_byte};
                        if (mask_q[3]) led_blink_rght_rgb_o <= {data_q, green_q, rx_byte};
                      end
                    end
`endif
                    default: ;
                  endcase
                end
              end
              default: ;
            endcase
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q == 3'd0) begin
            miso_o <= tx_next[7];
            tx_q   <= {tx_next[6:0], 1'b0};
          end else begin
            miso_o <= tx_q[7];
            tx_q   <= {tx_q[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gopigo3_spi_responder.sv
// Self-checking bench for gopigo3_spi_responder: frame-level model plus per-cycle idle checks.
module tb_gopigo3_spi_responder;

  localparam logic [7:0] Addr = 8'h08;
  typedef logic [7:0] frame_t [10];

  logic        clk = 1'b0, rst = 1'b0, sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0;
  logic [31:0] tl = 32'h0, tr = 32'h0;
  logic        miso_o, miso_en_o, dps_upd_o, ticks_rd_left_o, ticks_rd_rght_o, frame_err_o;
  logic [15:0] dps_l, dps_r;
`ifdef GOPIGO3_RESP_LED_EN
  logic [23:0] led [4];
`endif

  gopigo3_spi_responder #(.G_ADDR(Addr)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .sclk_i              (sclk),
    .ss_n_i              (ss_n),
    .mosi_i              (mosi),
    .miso_o              (miso_o),
    .miso_en_o           (miso_en_o),
    .motor_ticks_left_i  (tl),
    .motor_ticks_rght_i  (tr),
    .motor_dps_left_o    (dps_l),
    .motor_dps_rght_o    (dps_r),
    .dps_upd_o           (dps_upd_o),
    .ticks_rd_left_o     (ticks_rd_left_o),
    .ticks_rd_rght_o     (ticks_rd_rght_o),
`ifdef GOPIGO3_RESP_LED_EN
    .led_eye_left_rgb_o  (led[0]),
    .led_eye_rght_rgb_o  (led[1]),
    .led_blink_left_rgb_o(led[2]),
    .led_blink_rght_rgb_o(led[3]),
`endif
    .frame_err_o         (frame_err_o)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int c_upd = 0, c_tl = 0, c_tr = 0, c_err = 0;
  bit quiet = 1'b0;

  // Model state: what the persistent outputs must hold between frames.
  logic [15:0] m_dps_l = 16'h0, m_dps_r = 16'h0;
  logic [23:0] m_led [4] = '{24'h0, 24'h0, 24'h0, 24'h0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails < 40) $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dps_upd_o)       c_upd++;
    if (ticks_rd_left_o) c_tl++;
    if (ticks_rd_rght_o) c_tr++;
    if (frame_err_o)     c_err++;
  end

  // Between frames every persistent output must match the model and the bus must be released.
  always @(negedge clk) begin
    if (quiet) begin
      chk("idle dps_left", {16'h0, dps_l}, {16'h0, m_dps_l});
      chk("idle dps_rght", {16'h0, dps_r}, {16'h0, m_dps_r});
      chk("idle miso_en", {31'h0, miso_en_o}, 32'h0);
`ifdef GOPIGO3_RESP_LED_EN
      for (int k = 0; k < 4; k++) chk("idle led", {8'h0, led[k]}, {8'h0, m_led[k]});
`endif
    end
  end

  // Expected response of a frame of n bytes, and its effect on the persistent outputs.
  task automatic model(input frame_t b, input int n, output frame_t erx, output int een [10],
                       output int eu, output int etl, output int etr, output int ee);
    int len;
    bit aok, tok;
    logic [31:0] snap;
    logic [7:0]  t, m;
    len = 0;
    aok = (n >= 1) && (b[0] == Addr);
    t = b[1];
    m = b[2];
    if (t == 8'h11 || t == 8'h12) len = 7;
    else if (t == 8'h13) len = 5;
`ifdef GOPIGO3_RESP_LED_EN
    else if (t == 8'h14) len = 6;
`endif
    tok = aok && (n >= 2) && (len != 0);
    snap = (t == 8'h11) ? tl : tr;
    for (int i = 0; i < 10; i++) begin
      erx[i] = 8'h00;
      een[i] = (i == 0) ? 1 : (i == 1) ? int'(aok) : int'(tok);
      if (tok && len == 7 && i == 2) erx[i] = 8'hA5;
      if (tok && len == 7 && i >= 3 && i <= 6) erx[i] = snap[8*(6-i) +: 8];
    end
    ee  = int'(aok && (n == 1 || (len != 0 && n >= 2 && n < len)));
    etl = int'(tok && t == 8'h11);
    etr = int'(tok && t == 8'h12);
    eu  = 0;
    if (tok && t == 8'h13 && n >= 5) begin
      if (m[0]) m_dps_l = {b[3], b[4]};
      if (m[1]) m_dps_r = {b[3], b[4]};
      eu = int'(m[1:0] != 2'b00);
    end
`ifdef GOPIGO3_RESP_LED_EN
    if (tok && t == 8'h14 && n >= 6)
      for (int k = 0; k < 4; k++) if (m[k]) m_led[k] = {b[3], b[4], b[5]};
`endif
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx, output int en);
    int ones;
    ones = 0;
    rx = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      mosi = tx[i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      rx = {rx[6:0], miso_o};
      ones += int'(miso_en_o);
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
    en = (ones == 8) ? 1 : (ones == 0) ? 0 : 2;
  endtask

  task automatic run_frame(input string nm, input frame_t b, input int n, input bit swap,
                           output frame_t rx);
    frame_t erx;
    int een [10];
    int eu, etl, etr, ee, en, u0, tl0, tr0, e0;
    quiet = 1'b0;
    model(b, n, erx, een, eu, etl, etr, ee);
    u0 = c_upd; tl0 = c_tl; tr0 = c_tr; e0 = c_err;
    ss_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < n; i++) begin
      spi_byte(b[i], rx[i], en);
      chk($sformatf("%s en byte%0d", nm, i), en, een[i]);
      if (een[i] == 1) chk($sformatf("%s miso byte%0d", nm, i), {24'h0, rx[i]}, {24'h0, erx[i]});
      if (swap && i == 2) begin
        tl = ~tl;
        tr = ~tr;
      end
    end
    repeat (4) @(negedge clk);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
    chk({nm, " dps_upd pulses"}, c_upd - u0, eu);
    chk({nm, " ticks_rd_left pulses"}, c_tl - tl0, etl);
    chk({nm, " ticks_rd_rght pulses"}, c_tr - tr0, etr);
    chk({nm, " frame_err pulses"}, c_err - e0, ee);
    quiet = 1'b1;
  endtask

  frame_t f, rx;
  int en, tl0;
  logic [7:0] get_exp [7];

  initial begin
    repeat (3) @(negedge clk);
    chk("reset dps_left", {16'h0, dps_l}, 32'h0);
    chk("reset dps_rght", {16'h0, dps_r}, 32'h0);
    chk("reset miso/en", {30'h0, miso_o, miso_en_o}, 32'h0);
    chk("reset pulses", {28'h0, dps_upd_o, ticks_rd_left_o, ticks_rd_rght_o, frame_err_o}, 32'h0);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    quiet = 1'b1;

    f = '{8'h08, 8'h13, 8'h01, 8'h01, 8'h2C, 0, 0, 0, 0, 0};
    run_frame("set_left", f, 5, 1'b0, rx);
    chk("set_left literal dps_left", {16'h0, dps_l}, 32'h0000_012C);
    chk("set_left literal dps_rght", {16'h0, dps_r}, 32'h0);

    tl = 32'hFFFF_FF9C;
    f = '{8'h08, 8'h11, 0, 0, 0, 0, 0, 0, 0, 0};
    run_frame("get_left", f, 7, 1'b1, rx);
    get_exp = '{8'h00, 8'h00, 8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'h9C};
    for (int i = 0; i < 7; i++)
      chk($sformatf("get_left literal byte%0d", i), {24'h0, rx[i]}, {24'h0, get_exp[i]});

    tr = 32'h0102_0304;
    f = '{8'h08, 8'h12, 0, 0, 0, 0, 0, 0, 0, 0};
    run_frame("get_rght_long", f, 9, 1'b0, rx);

    f = '{8'h09, 8'h13, 8'h03, 8'h00, 8'h64, 0, 0, 0, 0, 0};
    run_frame("wrong_addr", f, 5, 1'b0, rx);

    f = '{8'h08, 8'h13, 8'h03, 8'h00, 0, 0, 0, 0, 0, 0};
    run_frame("truncated", f, 4, 1'b0, rx);
    f = '{8'h08, 8'h13, 8'h03, 8'hFF, 8'h38, 0, 0, 0, 0, 0};
    run_frame("set_both", f, 5, 1'b0, rx);
    chk("set_both literal dps_rght", {16'h0, dps_r}, 32'h0000_FF38);

    f = '{8'h08, 8'h13, 8'h00, 8'h12, 8'h34, 0, 0, 0, 0, 0};
    run_frame("mask_zero", f, 5, 1'b0, rx);
    f = '{8'h08, 8'h13, 8'h02, 8'h7F, 8'hFF, 8'hAB, 8'hCD, 0, 0, 0};
    run_frame("set_rght_extra", f, 7, 1'b0, rx);
    f = '{8'h08, 8'h55, 8'h01, 8'h00, 8'h10, 0, 0, 0, 0, 0};
    run_frame("unknown_type", f, 5, 1'b0, rx);
    f = '{8'h08, 8'h14, 8'h05, 8'hFF, 8'h80, 8'h00, 0, 0, 0, 0};
    run_frame("set_led", f, 6, 1'b0, rx);
`ifdef GOPIGO3_RESP_LED_EN
    chk("set_led literal eye_left", {8'h0, led[0]}, 32'h00FF_8000);
    chk("set_led literal eye_rght", {8'h0, led[1]}, 32'h0);
`endif
    f = '{8'h08, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    run_frame("addr_only", f, 1, 1'b0, rx);

    // Reset in the middle of a GET with ss_n held low.
    quiet = 1'b0;
    tl = 32'h1357_9BDF;
    tl0 = c_tl;
    ss_n = 1'b0;
    repeat (4) @(negedge clk);
    spi_byte(8'h08, rx[0], en);
    spi_byte(8'h11, rx[1], en);
    spi_byte(8'h00, rx[2], en);
    chk("rst_mid byte2", {24'h0, rx[2]}, 32'h0000_00A5);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    m_dps_l = 16'h0;
    m_dps_r = 16'h0;
`ifdef GOPIGO3_RESP_LED_EN
    for (int k = 0; k < 4; k++) m_led[k] = 24'h0;
`endif
    chk("rst_mid dps_left", {16'h0, dps_l}, 32'h0);
    chk("rst_mid dps_rght", {16'h0, dps_r}, 32'h0);
    chk("rst_mid miso_en", {31'h0, miso_en_o}, 32'h0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 3; i < 7; i++) begin
      spi_byte(8'h00, rx[i], en);
      chk($sformatf("rst_mid en byte%0d", i), en, 0);
    end
    repeat (4) @(negedge clk);
    ss_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("rst_mid ticks_rd_left pulses", c_tl - tl0, 1);
    quiet = 1'b1;

    f = '{8'h08, 8'h11, 0, 0, 0, 0, 0, 0, 0, 0};
    run_frame("get_after_rst", f, 7, 1'b0, rx);
    f = '{8'h08, 8'h13, 8'h01, 8'h80, 8'h01, 0, 0, 0, 0, 0};
    run_frame("set_after_rst", f, 5, 1'b0, rx);
    repeat (10) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gopigo3_spi_responder.md
GOPIGO3_SPI_RESPONDER -- requirements
Module: gopigo3_spi_responder

Interface
REQ-001 The block SHALL provide parameter G_ADDR, default 8'h08: frame address byte this responder answers to.
REQ-002 The block SHALL provide port clk, input, 1: system clock; all logic on rising edge.
REQ-003 The block SHALL provide port rst, input, 1: reset, asynchronous and active-low.
REQ-004 The block SHALL provide ports sclk_i, ss_n_i and mosi_i, inputs, 1 each: SPI clock, active-low slave select, and controller-to-responder data.
REQ-005 The block SHALL provide ports miso_o and miso_en_o, outputs, 1 each: responder data, and MISO drive enable (1 only while addressed).
REQ-006 The block SHALL provide ports motor_ticks_left_i and motor_ticks_rght_i, inputs, 32 each: encoder tick counts, 2's complement.
REQ-007 The block SHALL provide ports motor_dps_left_o and motor_dps_rght_o, outputs, 16 each: last commanded DPS.
REQ-008 The block SHALL provide port dps_upd_o, output, 1: one-clk pulse when any DPS output updates.
REQ-009 The block SHALL provide ports ticks_rd_left_o and ticks_rd_rght_o, outputs, 1 each: one-clk pulse when a tick snapshot is taken.
REQ-010 The block SHALL provide port frame_err_o, output, 1: one-clk pulse on a truncated frame.

Function
REQ-011 sclk_i, ss_n_i and mosi_i SHALL each pass through a 2-FF synchronizer; edge detect on synchronized sclk; supported sclk <= clk/4.
REQ-012 SPI SHALL be mode 0, MSB first: mosi sampled on sclk rising, miso changed on sclk falling; the first bit SHALL be valid from the ss_n falling detect.
REQ-013 The FSM states SHALL be IDLE, ADDR, TYPE, PAYLOAD, IGNORE; ss_n fall: IDLE->ADDR; byte 0 == G_ADDR: ->TYPE, else ->IGNORE with miso_en_o=0.
REQ-014 miso_en_o SHALL be 1 from ss_n fall until ss_n rise, except in IGNORE.
REQ-015 Message types SHALL be 8'h11 GET_TICKS_LEFT, 8'h12 GET_TICKS_RGHT, 8'h13 SET_DPS; any other type ->IGNORE.
REQ-016 MISO SHALL output 8'h00 during bytes 0-1 and during any byte beyond the message length.
REQ-017 GET (7 bytes): at byte-1 completion, snapshot the selected ticks and pulse the matching ticks_rd_*_o in that clk; byte2 = 8'hA5, bytes 3-6 = snapshot MSB first.
REQ-018 SET_DPS (5 bytes): byte2 = port mask (bit0 left, bit1 right), bytes 3-4 = DPS MSB, LSB; at byte-4 completion, masked outputs SHALL update in 1 clk with a single dps_upd_o pulse; mask 0 SHALL cause no update and no pulse.
REQ-019 ss_n rise SHALL go to IDLE from any state; a partial byte SHALL be discarded.
REQ-020 If ss_n rises in TYPE or PAYLOAD before the message length is reached, frame_err_o SHALL pulse once and no output SHALL update.
REQ-021 Bytes after a completed message SHALL be ignored, with no second update.
REQ-022 Tick inputs changing during GET bytes 3-6 SHALL NOT affect transmitted data.

Reset
REQ-023 Reset SHALL clear all outputs: DPS = 16'h0000; miso_o, miso_en_o, dps_upd_o, ticks_rd_*_o and frame_err_o = 0.
REQ-024 Reset SHALL clear the shift registers, snapshot and bit/byte counters.
REQ-025 If ss_n_i is low at reset release, the FSM SHALL enter IGNORE until ss_n rises; no mid-frame resync.

Configuration
REQ-026 With GOPIGO3_RESP_LED_EN defined, the block SHALL add type 8'h14 SET_LED (6 bytes): byte2 mask (bit0 eye left, bit1 eye right, bit2 blink left, bit3 blink right), bytes 3-5 R,G,B.
REQ-027 With GOPIGO3_RESP_LED_EN defined, the block SHALL add outputs led_eye_left_rgb_o, led_eye_rght_rgb_o, led_blink_left_rgb_o and led_blink_rght_rgb_o, 24 bits each {R,G,B}, reset 0, updated at byte-5 completion.
REQ-028 Without GOPIGO3_RESP_LED_EN, those ports SHALL NOT exist and 8'h14 SHALL be handled as an unknown type.

Verification
REQ-029 A bench SHALL send frame 08 13 01 01 2C -> motor_dps_left_o = 16'h012C, rght = 0, exactly one dps_upd_o pulse.
REQ-030 A bench SHALL set ticks_left = 32'hFFFF_FF9C and send 08 11 + 5x00 -> MISO 00 00 A5 FF FF FF 9C, one ticks_rd_left_o pulse, and ticks changed mid-frame have no effect.
REQ-031 A bench SHALL send frame 09 13 03 00 64 -> miso_en_o = 0 after byte 0, no output change, no pulse.
REQ-032 A bench SHALL send 08 13 03 00 then raise ss_n -> frame_err_o pulses once, DPS unchanged; a following valid frame is accepted.
REQ-033 A bench SHALL assert rst low mid-GET with ss_n held low -> outputs reset, rest of frame ignored; the next frame is answered normally.
REQ-034 A bench SHALL, with GOPIGO3_RESP_LED_EN, send 08 14 05 FF 80 00 -> led_eye_left and led_blink_left = 24'hFF8000, others 0; without the macro, no ports change.
